// File: rtl/stream_upsizer.sv
// Packs RATIO consecutive IN_WIDTH beats into one OUT_WIDTH word, flushing partial
// words on last_in with a per-lane keep mask (padding lanes read as zero).
module stream_upsizer #(
  parameter  int IN_WIDTH  = 8,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 valid_in,
  input  logic                 last_in,
  output logic                 ready_in,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic [RATIO-1:0]     keep_out,
  output logic                 last_out,
  output logic                 valid_out,
  input  logic                 ready_out
);

  localparam int CW = $clog2(RATIO);

  logic [CW-1:0]        cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [RATIO-1:0]     acc_keep;
  logic [OUT_WIDTH-1:0] merged_data;
  logic [RATIO-1:0]     merged_keep;
  logic                 insert;
  logic                 remove;
  logic                 complete;

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // a producer holds valid and payload steady until that edge. ready_in depends
  // only on the output register and ready_out, never on valid_in.
  assign ready_in = ~valid_out | ready_out;
  assign insert   = valid_in & ready_in;
  assign remove   = valid_out & ready_out;
  assign complete = insert & ((cnt == CW'(RATIO - 1)) | last_in);

  // Accumulator with the incoming beat dropped into lane cnt.
  always_comb begin
    merged_data = acc;
    merged_keep = acc_keep;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CW'(k)) begin
        merged_data[k*IN_WIDTH +: IN_WIDTH] = data_in;
        merged_keep[k]                      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      acc       <= '0;
      acc_keep  <= '0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      if (remove) begin
        valid_out <= 1'b0;
      end
      // A completing insert overrides the remove above, so back-to-back words
      // stream without a bubble.
      if (insert) begin
        if (complete) begin
          data_out  <= merged_data;
          keep_out  <= merged_keep;
          last_out  <= last_in;
          valid_out <= 1'b1;
          cnt       <= '0;
          acc       <= '0;
          acc_keep  <= '0;
        end else begin
          acc       <= merged_data;
          acc_keep  <= merged_keep;
          cnt       <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
